// File: rtl/frac_ds_pkg.sv
// Shared types and Q8.8 helpers for the fractional-stride downsampler.
// DS_ROUND_EN selects round-half-up target indices instead of floor.
package frac_ds_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  localparam int unsigned ONE_Q8_8  = 256;
  localparam int unsigned HALF_Q8_8 = 128;

  function automatic logic [31:0] q88_target(input logic [31:0] acc);
`ifdef DS_ROUND_EN
    return (acc + HALF_Q8_8) >> 8;
`else
    return acc >> 8;
`endif
  endfunction

endpackage

// File: rtl/ds_axis_sel.sv
// One axis of the downsampler: input index wrap counter, Q8.8 target
// accumulator and emitted-output counter, with the index==target compare.
module ds_axis_sel
  import frac_ds_pkg::*;
#(
  parameter int IDXW = 6,
  parameter int SW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            step_i,
  input  logic            adv_i,
  input  logic            rst_acc_i,
  input  logic [IDXW:0]   lim_i,
  input  logic [SW-1:0]   stride_i,
  output logic            last_o,
  output logic            hit_o,
  output logic [IDXW:0]   ocnt_o
);

  localparam int AW = IDXW + 9;
  localparam logic [AW-1:0] AMAX = {AW{1'b1}};

  logic [IDXW-1:0] idx_q, idx_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [IDXW:0]   ocnt_q, ocnt_d;
  logic [31:0]     sum;

  assign last_o = ({1'b0, idx_q} == (lim_i - 1'b1));
  assign hit_o  = (q88_target(32'(acc_q)) == 32'(idx_q));
  assign ocnt_o = ocnt_q;

  // Saturate so a huge stride cannot wrap back into a reachable target.
  assign sum = 32'(acc_q) + 32'(stride_i);

  always_comb begin
    idx_d  = idx_q;
    acc_d  = acc_q;
    ocnt_d = ocnt_q;
    if (step_i) idx_d = last_o ? '0 : idx_q + 1'b1;
    if (adv_i) begin
      acc_d  = (sum > 32'(AMAX)) ? AMAX : AW'(sum);
      ocnt_d = ocnt_q + 1'b1;
    end
    if (rst_acc_i) begin
      acc_d  = '0;
      ocnt_d = '0;
    end
    if (clr_i) begin
      idx_d  = '0;
      acc_d  = '0;
      ocnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q  <= '0;
      acc_q  <= '0;
      ocnt_q <= '0;
    end else begin
      idx_q  <= idx_d;
      acc_q  <= acc_d;
      ocnt_q <= ocnt_d;
    end
  end

endmodule

// File: rtl/frac_stride_downsampler.sv
// Streaming nearest-neighbour fractional-stride downsampler, square raster.
// Define DS_ROUND_EN for round-half-up index selection (see frac_ds_pkg).
module frac_stride_downsampler
  import frac_ds_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CH    = 1,
  parameter int MAX_H = 64,
  parameter int IDXW  = $clog2(MAX_H),
  parameter int SW    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [SW-1:0]      cfg_stride_q8_8,
  input  logic [IDXW:0]      cfg_hin,
  input  logic [IDXW:0]      cfg_hout,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CH*DW-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH*DW-1:0]   out_data,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic               ovf
);

  localparam logic [IDXW:0] MAXH_V = (IDXW + 1)'(MAX_H);

  state_e             state_q;
  logic [SW-1:0]      stride_q;
  logic [IDXW:0]      hin_q, hout_q;
  logic               out_valid_q, out_last_q, done_q, cfg_err_q, ovf_q, short_q;
  logic [CH*DW-1:0]   out_data_q;

  logic          cfg_ok, launch, beat, sel, row_end, row_adv, row_short, frame_end;
  logic          x_last, x_hit, y_last, y_hit;
  logic [IDXW:0] ox, oy, ox_after, oy_after;

  assign cfg_ok = (cfg_stride_q8_8 >= SW'(ONE_Q8_8)) && (cfg_hin != '0) &&
                  (cfg_hout != '0) && (cfg_hin <= MAXH_V) &&
                  (cfg_hout <= MAXH_V) && (cfg_hout <= cfg_hin);
  assign launch = start && (state_q == IDLE) && cfg_ok;

  assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
  assign beat      = in_valid && in_ready;
  assign sel       = beat && x_hit && y_hit && (ox < hout_q) && (oy < hout_q);
  assign row_end   = beat && x_last;
  assign row_adv   = row_end && y_hit && (oy < hout_q);
  assign frame_end = row_end && y_last;

  // Row shortfall must include a pixel selected on the row's final beat.
  assign ox_after  = ox + {{IDXW{1'b0}}, sel};
  assign oy_after  = oy + {{IDXW{1'b0}}, row_adv};
  assign row_short = row_adv && (ox_after < hout_q);

  ds_axis_sel #(.IDXW(IDXW), .SW(SW)) u_x (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (launch),
    .step_i    (beat),
    .adv_i     (sel),
    .rst_acc_i (row_end),
    .lim_i     (hin_q),
    .stride_i  (stride_q),
    .last_o    (x_last),
    .hit_o     (x_hit),
    .ocnt_o    (ox)
  );

  ds_axis_sel #(.IDXW(IDXW), .SW(SW)) u_y (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (launch),
    .step_i    (row_end),
    .adv_i     (row_adv),
    .rst_acc_i (1'b0),
    .lim_i     (hin_q),
    .stride_i  (stride_q),
    .last_o    (y_last),
    .hit_o     (y_hit),
    .ocnt_o    (oy)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stride_q    <= '0;
      hin_q       <= '0;
      hout_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      ovf_q       <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      if (sel) begin
        out_valid_q <= 1'b1;
        out_data_q  <= in_data;
        out_last_q  <= (ox == hout_q - 1'b1) && (oy == hout_q - 1'b1);
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              stride_q <= cfg_stride_q8_8;
              hin_q    <= cfg_hin;
              hout_q   <= cfg_hout;
              ovf_q    <= 1'b0;
              short_q  <= 1'b0;
              state_q  <= RUN;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (row_short) short_q <= 1'b1;
          if (frame_end) begin
            ovf_q   <= short_q || row_short || (oy_after < hout_q);
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!out_valid_q || out_ready) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/frac_stride_downsampler.md
Name: frac_stride_downsampler

Overview:
Streaming successor to the combinational fractional-stride downsampler.
- Accepts a square raster-ordered input feature map of CH channels per pixel over a valid/ready stream.
- Emits the nearest-neighbour downsampled map, selecting input index floor(o*stride) on each axis.
- Stride (Q8.8), hin and hout are runtime-configurable per frame, latched on start.
- Sits between the patch-embedding stage and the next transformer stage.

Parameters:
DW, 8, bits per channel sample
CH, 1, channels packed per pixel beat
MAX_H, 64, maximum hin/hout supported
IDXW, $clog2(MAX_H), row/column index width
SW, 16, stride width (Q8.8 unsigned)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; latches cfg_* when IDLE, ignored otherwise
cfg_stride_q8_8  in  SW  stride, Q8.8 (369 = 1.44)
cfg_hin  in  IDXW+1  input height/width
cfg_hout  in  IDXW+1  output height/width
in_valid  in  1  input pixel valid
in_ready  out  1  input pixel accepted when in_valid&&in_ready
in_data  in  CH*DW  input pixel, channel 0 in LSBs
out_valid  out  1  output pixel valid
out_ready  in  1  downstream ready
out_data  out  CH*DW  output pixel
out_last  out  1  high with final output pixel (oy=ox=hout-1)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at frame completion
cfg_err  out  1  one-cycle pulse when start is rejected
ovf  out  1  sticky; fewer than hout*hout pixels emitted; cleared on accepted start

Behaviour:
- Reset: state IDLE; all outputs 0; counters and accumulators 0.
- Synchronous active-low reset with one clock (clk/rst_n); reset mid-frame aborts with no done pulse.
- FSM states:
  - IDLE: on start, check legality.
    - Illegal if stride<256, hin==0, hout==0, hin>MAX_H, hout>MAX_H, or hout>hin.
    - Illegal: cfg_err pulses, stay IDLE.
    - Legal: latch config, clear ovf, go RUN.
  - RUN: consume exactly hin*hin input beats; go DRAIN after the last beat is accepted.
  - DRAIN: wait until out_valid is low or the final beat is taken; pulse done; go IDLE.
- Input counters ix and iy wrap ix at hin-1.
- Column accumulator acc_x (IDXW+8+1 bits) resets to 0 at each row start; row accumulator acc_y resets at frame start.
- Selection targets: tx = acc_x>>8, ty = acc_y>>8.
- An accepted beat is selected iff iy==ty && ix==tx && ox<hout && oy<hout.
  - Selected beat: register to output; ox++; acc_x += stride.
- At the end of an input row where iy==ty: oy++; acc_y += stride; ox=0.
- Unselected beats are accepted and dropped.
- in_ready = (state==RUN) && (!out_valid || out_ready).
  - One-deep output register; latency 1 cycle from acceptance to out_valid.
  - Full throughput when out_ready is held high.
- out_valid holds, with data stable, until out_ready.
- ovf set at frame end if oy<hout or any row emitted fewer than hout pixels (target beyond hin-1).
- Stride ≥256 guarantees strictly increasing targets, so no pixel is duplicated.
- start during RUN/DRAIN: ignored, no cfg_err.

Optional Feature:
Macro DS_ROUND_EN.
- Defined: targets are round-half-up, tx=(acc_x+128)>>8 and ty likewise.
  - A target exceeding hin-1 is treated as an overrun (ovf), not clamped.
- Undefined: floor, as above.

Decomposition:
- Package frac_ds_pkg holds:
  - state enum (IDLE/RUN/DRAIN);
  - Q8.8 constants ONE_Q8_8=256 and HALF_Q8_8=128;
  - function q88_target(acc) returning the index (floor or round per macro).
- One sub-module, ds_axis_sel, is instantiated twice (x and y). It contains:
  - accumulator;
  - target compare;
  - wrap counter.

Test Plan:
- hin=27, hout=19, stride=369, CH=1, in(i,j)=10*(i+j) mod 256, out_ready=1 → 361 outputs. out(1,1)=20, out(3,3)=80, out(18,18)=244. out_last on beat 361; done 1 cycle after.
- Same with DS_ROUND_EN → out(18,18)=in(26,26)=8, out(3,3)=80, ovf=0.
- Random out_ready backpressure (50%) and in_valid gaps, CH=3 → output identical to the no-stall run; no beat lost or duplicated.
- start with stride=200 → cfg_err pulse, busy stays 0. start with hout=28, hin=27 → cfg_err.
- hin=10, hout=8, stride=384 → targets 0,1,3,4,6,7,9,10. Target 10 overruns, so 7x7 outputs are emitted and ovf=1 after done.
- rst_n low mid-RUN, then a new legal start → clean frame; no done pulse from the aborted frame.
